// File: rtl/servo_access_arbiter_pkg.sv
// Shared types and constants for the servo access arbiter and its slew limiter.
// Holds requester indices, FSM state encodings, default angles and the clamp helper.
package servo_access_arbiter_pkg;

  typedef logic [7:0] angle_t;

  localparam int REQ_EV1 = 0;
  localparam int REQ_EV2 = 1;
  localparam int REQ_PUZ = 2;
  localparam int N_REQ_DEFAULT = REQ_PUZ + 1;

  localparam angle_t IDLE_ANGLE_DEFAULT = 8'd90;
  localparam angle_t MAX_ANGLE_DEFAULT  = 8'd180;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OWNED  = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  function automatic angle_t clampAngle(input angle_t a, input angle_t ceiling);
    return (a > ceiling) ? ceiling : a;
  endfunction

endpackage

// File: rtl/servo_slew_limiter.sv
// Rate limiter that walks angle_out toward target by at most SLEW_STEP per tick.
// Only present when SERVO_ARB_SLEW_EN is defined; the arbiter bypasses it otherwise.
`ifdef SERVO_ARB_SLEW_EN
module servo_slew_limiter
  import servo_access_arbiter_pkg::*;
#(
  parameter angle_t IDLE_ANGLE = IDLE_ANGLE_DEFAULT,
  parameter angle_t SLEW_STEP  = 8'd2
) (
  input  logic   clk,
  input  logic   rst,
  input  angle_t target,
  input  logic   tick,
  output angle_t angle_out,
  output logic   settled
);

  angle_t angle_q, angle_d, dist, stepSize;
  logic   goUp;

  // Direction is decided before subtracting so the distance never wraps,
  // and the step is capped by the remaining distance so it never overshoots.
  always_comb begin
    goUp     = target > angle_q;
    dist     = goUp ? (target - angle_q) : (angle_q - target);
    stepSize = (dist < SLEW_STEP) ? dist : SLEW_STEP;
    angle_d  = angle_q;
    if (tick) begin
      angle_d = goUp ? (angle_q + stepSize) : (angle_q - stepSize);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_q <= IDLE_ANGLE;
    end else begin
      angle_q <= angle_d;
    end
  end

  assign angle_out = angle_q;
  assign settled   = (angle_q == target);

endmodule
`endif

// File: rtl/servo_access_arbiter.sv
// Fixed-priority servo owner arbiter with preemption, angle clamping and a registered output angle.
// Build option: define SERVO_ARB_SLEW_EN to slew-limit angle_out; otherwise angle_out follows the target one cycle later.
module servo_access_arbiter
  import servo_access_arbiter_pkg::*;
#(
  parameter int     N_REQ      = N_REQ_DEFAULT,
  parameter angle_t IDLE_ANGLE = IDLE_ANGLE_DEFAULT,
  parameter angle_t MAX_ANGLE  = MAX_ANGLE_DEFAULT,
  parameter int     SLEW_DIV   = 50000,
  parameter angle_t SLEW_STEP  = 8'd2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] angle_req,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         angle_out,
  output logic               settled,
  output logic               preempt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, bestOneHot;
  logic [IDX_W-1:0] bestIdx, ownerIdx;
  logic             anyReq, preempt_q, preempt_d;
  angle_t           target_q, target_d, angleNow;

  // Lowest set index wins; descending loop leaves the smallest index last.
  always_comb begin
    bestIdx  = '0;
    ownerIdx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        bestIdx = IDX_W'(i);
      end
      if (grant_q[i]) begin
        ownerIdx = IDX_W'(i);
      end
    end
    anyReq     = |req;
    bestOneHot = req & (~req + N_REQ'(1));
  end

  // While owned, the best pending request always takes the grant; it only
  // counts as preemption when it outranks the current owner.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          state_d = ST_OWNED;
          grant_d = bestOneHot;
        end
      end
      ST_OWNED: begin
        if (anyReq) begin
          grant_d   = bestOneHot;
          preempt_d = (bestIdx < ownerIdx);
        end else begin
          grant_d = '0;
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (anyReq) begin
          state_d = ST_OWNED;
          grant_d = bestOneHot;
        end else if (angleNow == IDLE_ANGLE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    target_d = IDLE_ANGLE;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_d[i]) begin
        target_d = clampAngle(angle_req[8*i +: 8], MAX_ANGLE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      preempt_q <= 1'b0;
      target_q  <= IDLE_ANGLE;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      preempt_q <= preempt_d;
      target_q  <= target_d;
    end
  end

`ifdef SERVO_ARB_SLEW_EN
  localparam int CNT_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

  logic [CNT_W-1:0] slewCnt_q;
  logic             slewTick;

  // Free-running divider; target changes deliberately do not restart it.
  assign slewTick = (slewCnt_q == CNT_W'(SLEW_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slewCnt_q <= '0;
    end else begin
      slewCnt_q <= slewTick ? '0 : (slewCnt_q + CNT_W'(1));
    end
  end

  servo_slew_limiter #(
    .IDLE_ANGLE (IDLE_ANGLE),
    .SLEW_STEP  (SLEW_STEP)
  ) u_slew (
    .clk       (clk),
    .rst       (rst),
    .target    (target_q),
    .tick      (slewTick),
    .angle_out (angleNow),
    .settled   (settled)
  );
`else
  angle_t angle_q;
  logic   unused_slew_cfg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_q <= IDLE_ANGLE;
    end else begin
      angle_q <= target_q;
    end
  end

  assign angleNow        = angle_q;
  assign settled         = (angle_q == target_q);
  assign unused_slew_cfg = ^{SLEW_DIV, SLEW_STEP};
`endif

  assign grant     = grant_q;
  assign preempt   = preempt_q;
  assign angle_out = angleNow;

endmodule
